// File: rtl/npc_pkg.sv
// Shared definitions for the NPC core front end: fetch FSM encoding and reset/instruction constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package npc_pkg;

    // Fetch FSM states.
    //   FETCH_REQ  : request presented to instruction memory
    //   FETCH_WAIT : request accepted, waiting for the response
    //   FETCH_HOLD : instruction buffered and offered to the decoder
    //   FETCH_HALT : stopped; only reset leaves this state
    typedef enum logic [1:0] {
        FETCH_REQ  = 2'd0,
        FETCH_WAIT = 2'd1,
        FETCH_HOLD = 2'd2,
        FETCH_HALT = 2'd3
    } fetch_state_e;

    localparam int          XLEN_DEFAULT     = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

    // addi x0, x0, 0
    localparam logic [31:0] INST_NOP         = 32'h0000_0013;
    // ebreak: the decoder raises halt when it sees this word
    localparam logic [31:0] INST_EBREAK      = 32'h0010_0073;

    // Sequential fetch stride.
    localparam int          INST_BYTES       = 4;

endpackage

// File: rtl/ifu_inst_buf.sv
// One-entry holding register for a fetched instruction and its address.
// Latency: load captured on the clock edge, visible the following cycle.
// Backpressure: none; the owner decides when to load or clear.
//
// Ports:
//   clk, rst            core clock, synchronous active-high reset (clears entry)
//   load                capture load_inst/load_pc this cycle
//   clear               drop the held contents (zeroes the entry)
//   load_inst, load_pc  word and its address to capture
//   inst, inst_pc       held word and address
module ifu_inst_buf #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            clear,
    input  logic [XLEN-1:0] load_inst,
    input  logic [XLEN-1:0] load_pc,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            inst    <= '0;
            inst_pc <= '0;
        end else if (load) begin
            inst    <= load_inst;
            inst_pc <= load_pc;
        end
    end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, fetches one word at a time from imem and offers it to the decoder.
// Latency: request accepted at t, response at t+k gives inst_valid at t+k+1; next request the cycle after consume.
// Backpressure: a held instruction stays stable until inst_ready; no new request is issued until it is consumed.
//
// Ports:
//   clk, rst                       core clock, synchronous active-high reset
//   imem_req_valid/ready/addr      fetch request to instruction memory (addr word aligned)
//   imem_rsp_valid/data/err        response from instruction memory, err = access fault
//   inst_valid/ready, inst/inst_pc instruction offered to the decoder
//   redirect_valid/redirect_pc     EXU branch/jump target for the next fetch
//   halt                           decoder stop request (level)
//   halted                         fetch stopped, no further requests
//   fetch_err                      sticky access-fault flag
module ifu_fetch
    import npc_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
    input  logic            clk,
    input  logic            rst,

    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            imem_rsp_err,

    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,

    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,

    input  logic            halt,
    output logic            halted,
    output logic            fetch_err
);

    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(INST_BYTES);

    fetch_state_e    state, state_nxt;
    logic [XLEN-1:0] pc, pc_nxt;
    // kill: the outstanding request belongs to a squashed path; its response is discarded
    logic            kill, kill_nxt;
    // halt_pend: halt arrived with a request in flight; stop once its response drains
    logic            halt_pend, halt_pend_nxt;
    logic            fetch_err_nxt;

    logic            buf_load;
    logic            buf_clear;

    logic            req_fire;
    logic            consume;
    logic [XLEN-1:0] redirect_tgt;
    logic [XLEN-1:0] pc_seq;

    // Outputs are forced quiet while reset is held so nothing leaks out on the reset cycle itself.
    assign imem_req_valid = (state == FETCH_REQ)  && !rst;
    assign inst_valid     = (state == FETCH_HOLD) && !rst;
    assign halted         = (state == FETCH_HALT) && !rst;
    assign imem_req_addr  = pc & ALIGN_MASK;

    assign req_fire     = imem_req_valid && imem_req_ready;
    assign consume      = inst_valid && inst_ready;
    assign redirect_tgt = redirect_pc & ALIGN_MASK;
    assign pc_seq       = pc + PC_STEP;   // wraps modulo 2^XLEN

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FETCH_REQ;
            pc        <= RESET_PC;
            kill      <= 1'b0;
            halt_pend <= 1'b0;
            fetch_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            kill      <= kill_nxt;
            halt_pend <= halt_pend_nxt;
            fetch_err <= fetch_err_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc;
        kill_nxt      = kill;
        halt_pend_nxt = halt_pend;
        fetch_err_nxt = fetch_err;
        buf_load      = 1'b0;
        buf_clear     = 1'b0;

        unique case (state)
            FETCH_REQ: begin
                if (halt) begin
                    // A request accepted this cycle must still see its response before stopping.
                    if (req_fire) begin
                        halt_pend_nxt = 1'b1;
                        state_nxt     = FETCH_WAIT;
                    end else begin
                        state_nxt = FETCH_HALT;
                    end
                end else begin
                    if (redirect_valid) begin
                        pc_nxt = redirect_tgt;
                        // Request went out with the old PC; its response is stale.
                        if (req_fire) begin
                            kill_nxt = 1'b1;
                        end
                    end
                    if (req_fire) begin
                        state_nxt = FETCH_WAIT;
                    end
                end
            end

            FETCH_WAIT: begin
                if (imem_rsp_valid) begin
                    if (halt || halt_pend) begin
                        // Drain and stop; a fault on a live response is still recorded.
                        if (!kill && imem_rsp_err) begin
                            fetch_err_nxt = 1'b1;
                        end
                        state_nxt = FETCH_HALT;
                    end else if (kill) begin
                        kill_nxt  = 1'b0;
                        if (redirect_valid) begin
                            pc_nxt = redirect_tgt;
                        end
                        state_nxt = FETCH_REQ;
                    end else if (redirect_valid) begin
                        // Response arrives together with a redirect: it is on the wrong path.
                        pc_nxt    = redirect_tgt;
                        state_nxt = FETCH_REQ;
                    end else if (imem_rsp_err) begin
                        fetch_err_nxt = 1'b1;
                        state_nxt     = FETCH_HALT;
                    end else begin
                        buf_load  = 1'b1;
                        state_nxt = FETCH_HOLD;
                    end
                end else begin
                    if (halt) begin
                        halt_pend_nxt = 1'b1;
                    end else if (redirect_valid) begin
                        pc_nxt   = redirect_tgt;
                        kill_nxt = 1'b1;
                    end
                end
            end

            FETCH_HOLD: begin
                if (halt) begin
                    buf_clear = 1'b1;
                    state_nxt = FETCH_HALT;
                end else if (consume) begin
                    pc_nxt    = redirect_valid ? redirect_tgt : pc_seq;
                    state_nxt = FETCH_REQ;
                end else if (redirect_valid) begin
                    // Held instruction is on the wrong path; drop it and refetch.
                    buf_clear = 1'b1;
                    pc_nxt    = redirect_tgt;
                    state_nxt = FETCH_REQ;
                end
            end

            FETCH_HALT: begin
                state_nxt = FETCH_HALT;
            end

            default: begin
                state_nxt = FETCH_REQ;
            end
        endcase
    end

    ifu_inst_buf #(
        .XLEN (XLEN)
    ) u_inst_buf (
        .clk       (clk),
        .rst       (rst),
        .load      (buf_load),
        .clear     (buf_clear),
        .load_inst (imem_rsp_data),
        .load_pc   (imem_req_addr),
        .inst      (inst),
        .inst_pc   (inst_pc)
    );

endmodule

// File: tb/tb_ifu_fetch.sv
// Testbench for ifu_fetch: plays instruction memory and decoder, checks against a PC/instruction model.
// Latency: n/a.
// Backpressure: n/a.
module tb_ifu_fetch;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        halted;
    logic        fetch_err;

    int          vectors;
    int          miscompares;
    logic [31:0] model_pc;   // address the next request must carry

    ifu_fetch #(
        .XLEN     (32),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .halted         (halted),
        .fetch_err      (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are changed here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        imem_rsp_err   = 1'b0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        halt           = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        step();
        @(negedge clk);
        check1 ("rst_req_valid",  imem_req_valid, 1'b0);
        check1 ("rst_inst_valid", inst_valid,     1'b0);
        check1 ("rst_halted",     halted,         1'b0);
        check1 ("rst_fetch_err",  fetch_err,      1'b0);
        check32("rst_inst",       inst,           32'h0);
        check32("rst_inst_pc",    inst_pc,        32'h0);
        step();
        rst      = 1'b0;
        model_pc = RESET_PC;
    endtask

    // Request accepted immediately, response after lat cycles, decoder stalls for stall cycles,
    // then consumes, optionally with a redirect in the consume cycle.
    task automatic do_fetch(input int lat, input int stall, input logic [31:0] data,
                            input logic redir, input logic [31:0] rpc);
        imem_req_ready = 1'b1;
        @(negedge clk);
        check1 ("req_valid",      imem_req_valid, 1'b1);
        check32("req_addr",       imem_req_addr,  model_pc);
        check1 ("req_inst_valid", inst_valid,     1'b0);
        step();
        imem_req_ready = 1'b0;
        for (int i = 1; i < lat; i++) begin
            @(negedge clk);
            check1("wait_req_valid",  imem_req_valid, 1'b0);
            check1("wait_inst_valid", inst_valid,     1'b0);
            step();
        end
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = data;
        @(negedge clk);
        check1("rsp_inst_valid", inst_valid, 1'b0);
        step();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check1 ("stall_inst_valid", inst_valid,     1'b1);
            check32("stall_inst",       inst,           data);
            check32("stall_inst_pc",    inst_pc,        model_pc);
            check1 ("stall_req_valid",  imem_req_valid, 1'b0);
            step();
        end
        inst_ready     = 1'b1;
        redirect_valid = redir;
        redirect_pc    = rpc;
        @(negedge clk);
        check1 ("hold_inst_valid", inst_valid, 1'b1);
        check32("hold_inst",       inst,       data);
        check32("hold_inst_pc",    inst_pc,    model_pc);
        step();
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        model_pc = redir ? (rpc & ~32'h3) : (model_pc + 32'd4);
    endtask

    // Redirect while the request is outstanding: the response must be dropped.
    task automatic redirect_in_wait(input logic [31:0] rpc);
        imem_req_ready = 1'b1;
        @(negedge clk);
        check32("rw_req_addr", imem_req_addr, model_pc);
        step();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = rpc;
        step();
        redirect_valid = 1'b0;
        @(negedge clk);
        check1("rw_req_valid", imem_req_valid, 1'b0);
        step();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = $urandom;
        @(negedge clk);
        check1("rw_inst_valid", inst_valid, 1'b0);
        step();
        imem_rsp_valid = 1'b0;
        model_pc = rpc & ~32'h3;
    endtask

    // Redirect while an instruction is held and not consumed: it must be dropped.
    task automatic redirect_in_hold(input logic [31:0] rpc);
        logic [31:0] data;
        data = $urandom;
        imem_req_ready = 1'b1;
        @(negedge clk);
        check32("rh_req_addr", imem_req_addr, model_pc);
        step();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = data;
        step();
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = rpc;
        @(negedge clk);
        check1 ("rh_inst_valid", inst_valid, 1'b1);
        check32("rh_inst",       inst,       data);
        step();
        redirect_valid = 1'b0;
        model_pc = rpc & ~32'h3;
    endtask

    // Redirect while the request is not yet accepted.
    task automatic redirect_in_req(input logic [31:0] rpc);
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = rpc;
        @(negedge clk);
        check1 ("rq_req_valid", imem_req_valid, 1'b1);
        check32("rq_req_addr",  imem_req_addr,  model_pc);
        step();
        redirect_valid = 1'b0;
        model_pc = rpc & ~32'h3;
    endtask

    initial begin
        int kind;
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        idle_inputs();
        model_pc    = RESET_PC;

        do_reset();

        // Back-to-back sequential fetch, one cycle imem latency.
        for (int i = 0; i < 3; i++) begin
            do_fetch(1, 0, $urandom, 1'b0, 32'h0);
        end
        check32("seq_model_pc", model_pc, RESET_PC + 32'd12);

        // Slow imem and a stalling decoder.
        do_fetch(4, 3, $urandom, 1'b0, 32'h0);

        // Redirect to a misaligned target while waiting on imem.
        redirect_in_wait(32'h8000_0102);
        do_fetch(1, 0, $urandom, 1'b0, 32'h0);

        // Halt while a request is outstanding.
        imem_req_ready = 1'b1;
        @(negedge clk);
        check32("halt_req_addr", imem_req_addr, model_pc);
        step();
        imem_req_ready = 1'b0;
        halt = 1'b1;
        @(negedge clk);
        check1("halt_wait_halted", halted, 1'b0);
        step();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0010_0073;
        @(negedge clk);
        check1("halt_rsp_inst_valid", inst_valid, 1'b0);
        step();
        imem_rsp_valid = 1'b0;
        imem_req_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check1("halt_halted",     halted,         1'b1);
            check1("halt_req_valid",  imem_req_valid, 1'b0);
            check1("halt_inst_valid", inst_valid,     1'b0);
            step();
        end
        do_reset();

        // Access fault on a live response.
        imem_req_ready = 1'b1;
        @(negedge clk);
        check32("err_req_addr", imem_req_addr, RESET_PC);
        step();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_err   = 1'b1;
        step();
        imem_rsp_valid = 1'b0;
        imem_rsp_err   = 1'b0;
        @(negedge clk);
        check1("err_fetch_err",  fetch_err,      1'b1);
        check1("err_halted",     halted,         1'b1);
        check1("err_inst_valid", inst_valid,     1'b0);
        check1("err_req_valid",  imem_req_valid, 1'b0);
        step();
        do_reset();
        do_fetch(1, 0, $urandom, 1'b0, 32'h0);

        // PC wrap at the top of the address space.
        do_fetch(2, 1, $urandom, 1'b1, 32'hFFFF_FFFF);
        do_fetch(1, 0, $urandom, 1'b0, 32'h0);
        check32("wrap_model_pc", model_pc, 32'h0);
        do_fetch(1, 0, $urandom, 1'b0, 32'h0);

        // Reset while waiting on imem.
        imem_req_ready = 1'b1;
        @(negedge clk);
        check1("rstw_req_valid", imem_req_valid, 1'b1);
        step();
        imem_req_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check1("rstw_req_valid_in_rst", imem_req_valid, 1'b0);
        check1("rstw_inst_valid",       inst_valid,     1'b0);
        step();
        rst      = 1'b0;
        model_pc = RESET_PC;
        do_fetch(1, 0, $urandom, 1'b0, 32'h0);

        // Randomised mix of fetches and redirects.
        for (int n = 0; n < 60; n++) begin
            kind = int'($urandom_range(0, 3));
            case (kind)
                0: do_fetch(int'($urandom_range(1, 4)), int'($urandom_range(0, 3)), $urandom,
                            ($urandom_range(0, 3) == 0), $urandom);
                1: redirect_in_wait($urandom);
                2: redirect_in_hold($urandom);
                default: redirect_in_req($urandom);
            endcase
        end
        do_fetch(1, 0, $urandom, 1'b0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
